// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Execute-stage ALU. Decodes ALUop/op_code/func3/func7 into a
//                4-bit operation, computes the RV32I/RV64I integer result and
//                holds it in a valid/ready output register. An optional
//                bit-serial shifter replaces the barrel shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
   parameter int XLEN         = 32,
   parameter bit SHIFT_SERIAL = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      ALUop,
   input  logic [6:0]      op_code,
   input  logic [2:0]      func3,
   input  logic [6:0]      func7,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic [3:0]      alu_control
);

   localparam int SHW = $clog2(XLEN);

   localparam logic [3:0] c_OP_ADD   = 4'b0000;
   localparam logic [3:0] c_OP_SUB   = 4'b0001;
   localparam logic [3:0] c_OP_AND   = 4'b0010;
   localparam logic [3:0] c_OP_OR    = 4'b0011;
   localparam logic [3:0] c_OP_XOR   = 4'b0100;
   localparam logic [3:0] c_OP_SLT   = 4'b0101;
   localparam logic [3:0] c_OP_SLTU  = 4'b0110;
   localparam logic [3:0] c_OP_SLL   = 4'b0111;
   localparam logic [3:0] c_OP_SRL   = 4'b1000;
   localparam logic [3:0] c_OP_SRA   = 4'b1001;
   localparam logic [3:0] c_OP_PASSB = 4'b1010;

   localparam logic [6:0] c_OPC_REG  = 7'b0110011;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      w_op;
   logic [XLEN-1:0] w_alu;
   logic [XLEN-1:0] w_step;
   logic [SHW-1:0]  w_shamt;
   logic            w_slt;
   logic            w_sltu;
   logic            w_is_shift;
   logic            w_go_serial;
   logic            w_accept;
   logic            w_cnt_zero;
   logic [XLEN-1:0] r_sh_val;
   logic [3:0]      r_sh_op;
   logic [SHW-1:0]  r_cnt;
   logic            w_unused_func7;

   // Only func7[5] distinguishes SUB/SRA; the remaining bits are don't-care.
   assign w_unused_func7 = ^{func7[6], func7[4:0]};

   assign w_shamt     = src_b[SHW-1:0];
   assign w_slt       = $signed(src_a) < $signed(src_b);
   assign w_sltu      = src_a < src_b;
   assign w_is_shift  = (w_op == c_OP_SLL) || (w_op == c_OP_SRL) || (w_op == c_OP_SRA);
   assign w_go_serial = SHIFT_SERIAL && w_is_shift && (w_shamt != '0);
   assign in_ready    = rst && !flush && (r_state == ST_IDLE) && (!out_valid || out_ready);
   assign w_accept    = in_valid && in_ready;
   assign w_cnt_zero  = (r_cnt == '0);

   // ALU control decode from the main-decoder ALUop and instruction fields.
   always_comb begin
      w_op = c_OP_ADD;
      case (ALUop)
         2'b00:   w_op = c_OP_ADD;
         2'b01:   w_op = c_OP_SUB;
         2'b11:   w_op = c_OP_PASSB;
         default: begin
            case (func3)
               // ADDI shares funct3 with ADD/SUB but has no func7 field.
               3'b000:  w_op = ((op_code == c_OPC_REG) && func7[5]) ? c_OP_SUB : c_OP_ADD;
               3'b001:  w_op = c_OP_SLL;
               3'b010:  w_op = c_OP_SLT;
               3'b011:  w_op = c_OP_SLTU;
               3'b100:  w_op = c_OP_XOR;
               3'b101:  w_op = func7[5] ? c_OP_SRA : c_OP_SRL;
               3'b110:  w_op = c_OP_OR;
               default: w_op = c_OP_AND;
            endcase
         end
      endcase
   end

   // Single-cycle datapath, including the barrel shifter.
   always_comb begin
      w_alu = '0;
      case (w_op)
         c_OP_ADD:   w_alu = src_a + src_b;
         c_OP_SUB:   w_alu = src_a - src_b;
         c_OP_AND:   w_alu = src_a & src_b;
         c_OP_OR:    w_alu = src_a | src_b;
         c_OP_XOR:   w_alu = src_a ^ src_b;
         c_OP_SLT:   w_alu = {{(XLEN-1){1'b0}}, w_slt};
         c_OP_SLTU:  w_alu = {{(XLEN-1){1'b0}}, w_sltu};
         c_OP_SLL:   w_alu = src_a << w_shamt;
         c_OP_SRL:   w_alu = src_a >> w_shamt;
         c_OP_SRA:   w_alu = $signed(src_a) >>> w_shamt;
         c_OP_PASSB: w_alu = src_b;
         default:    w_alu = '0;
      endcase
   end

   // One-bit step of the serial shifter.
   always_comb begin
      w_step = r_sh_val;
      case (r_sh_op)
         c_OP_SLL: w_step = {r_sh_val[XLEN-2:0], 1'b0};
         c_OP_SRL: w_step = {1'b0, r_sh_val[XLEN-1:1]};
         c_OP_SRA: w_step = {r_sh_val[XLEN-1], r_sh_val[XLEN-1:1]};
         default:  w_step = r_sh_val;
      endcase
   end

   // Next state: enter SHIFT on a serial shift accept, leave on done or flush.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept && w_go_serial) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (flush || w_cnt_zero)     w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Output register and serial shifter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid   <= 1'b0;
         result      <= '0;
         zero        <= 1'b0;
         alu_control <= c_OP_ADD;
         r_sh_val    <= '0;
         r_sh_op     <= c_OP_ADD;
         r_cnt       <= '0;
      end else if (flush) begin
         // Result fields intentionally keep their stale contents.
         out_valid <= 1'b0;
         r_cnt     <= '0;
      end else if (r_state == ST_SHIFT) begin
         if (w_cnt_zero) begin
            result      <= r_sh_val;
            zero        <= (r_sh_val == '0);
            alu_control <= r_sh_op;
            out_valid   <= 1'b1;
         end else begin
            r_sh_val <= w_step;
            r_cnt    <= r_cnt - SHW'(1);
         end
      end else if (w_accept) begin
         if (w_go_serial) begin
            r_sh_val  <= src_a;
            r_sh_op   <= w_op;
            r_cnt     <= w_shamt;
            out_valid <= 1'b0;
         end else begin
            result      <= w_alu;
            zero        <= (w_alu == '0);
            alu_control <= w_op;
            out_valid   <= 1'b1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Scoreboard bench for alu_exec_unit. Instance A is 32-bit with
//                the serial shifter, instance B is 64-bit with the barrel
//                shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_zero;
   logic [1:0]  a_ALUop;
   logic [6:0]  a_op_code, a_func7;
   logic [2:0]  a_func3;
   logic [31:0] a_src_a, a_src_b, a_result;
   logic [3:0]  a_alu_control;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zero;
   logic [1:0]  b_ALUop;
   logic [6:0]  b_op_code, b_func7;
   logic [2:0]  b_func3;
   logic [63:0] b_src_a, b_src_b, b_result;
   logic [3:0]  b_alu_control;
   logic        b_flush;

   int n_tests = 0;
   int n_fail  = 0;

   logic [67:0] qa[$];
   logic [67:0] qb[$];

   always #5 clk = ~clk;

   alu_exec_unit #(.XLEN(32), .SHIFT_SERIAL(1'b1)) u_dut_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .ALUop(a_ALUop), .op_code(a_op_code), .func3(a_func3), .func7(a_func7),
      .src_a(a_src_a), .src_b(a_src_b),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .result(a_result), .zero(a_zero), .alu_control(a_alu_control)
   );

   alu_exec_unit #(.XLEN(64), .SHIFT_SERIAL(1'b0)) u_dut_b (
      .clk(clk), .rst(rst), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .ALUop(b_ALUop), .op_code(b_op_code), .func3(b_func3), .func7(b_func7),
      .src_a(b_src_a), .src_b(b_src_b),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .result(b_result), .zero(b_zero), .alu_control(b_alu_control)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one operation, wait (bounded) for acceptance, record the expectation.
   task automatic issue(input bit sel, input logic [1:0] aluop, input logic [6:0] opc,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] er, input logic [3:0] ec, input bit push);
      int  t;
      logic rdy;
      if (!sel) begin
         a_in_valid = 1'b1; a_ALUop = aluop; a_op_code = opc; a_func3 = f3; a_func7 = f7;
         a_src_a = a[31:0]; a_src_b = b[31:0];
      end else begin
         b_in_valid = 1'b1; b_ALUop = aluop; b_op_code = opc; b_func3 = f3; b_func7 = f7;
         b_src_a = a; b_src_b = b;
      end
      t = 0;
      do begin
         @(negedge clk);
         t++;
         rdy = sel ? b_in_ready : a_in_ready;
      end while (!rdy && t < 100);
      check("issue_in_ready", {63'd0, rdy}, 64'd1);
      if (rdy) begin
         @(posedge clk);
         if (push) begin
            if (sel) qb.push_back({ec, er});
            else     qa.push_back({ec, er});
         end
      end
      #1;
      if (sel) b_in_valid = 1'b0;
      else     a_in_valid = 1'b0;
   endtask

   // Scoreboard monitor for instance A.
   always @(negedge clk) begin
      logic [67:0] e;
      if (rst && a_out_valid && a_out_ready) begin
         if (qa.size() == 0) begin
            check("a_unexpected_output", {63'd0, a_out_valid}, 64'd0);
         end else begin
            e = qa.pop_front();
            check("a_result", {32'd0, a_result}, {32'd0, e[31:0]});
            check("a_zero", {63'd0, a_zero}, {63'd0, (e[31:0] == 32'd0)});
            check("a_alu_control", {60'd0, a_alu_control}, {60'd0, e[67:64]});
         end
      end
   end

   // Scoreboard monitor for instance B.
   always @(negedge clk) begin
      logic [67:0] e;
      if (rst && b_out_valid && b_out_ready) begin
         if (qb.size() == 0) begin
            check("b_unexpected_output", {63'd0, b_out_valid}, 64'd0);
         end else begin
            e = qb.pop_front();
            check("b_result", b_result, e[63:0]);
            check("b_zero", {63'd0, b_zero}, {63'd0, (e[63:0] == 64'd0)});
            check("b_alu_control", {60'd0, b_alu_control}, {60'd0, e[67:64]});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      int t;
      rst = 1'b0; flush = 1'b0; b_flush = 1'b0;
      a_in_valid = 1'b1; a_ALUop = 2'b00; a_op_code = 7'b0110011; a_func3 = 3'b000;
      a_func7 = 7'b0; a_src_a = 32'd1; a_src_b = 32'd2; a_out_ready = 1'b1;
      b_in_valid = 1'b1; b_ALUop = 2'b00; b_op_code = 7'b0110011; b_func3 = 3'b000;
      b_func7 = 7'b0; b_src_a = 64'd1; b_src_b = 64'd2; b_out_ready = 1'b1;

      // Reset held with traffic offered.
      repeat (3) begin
         @(negedge clk);
         check("rst_a_out_valid", {63'd0, a_out_valid}, 64'd0);
         check("rst_a_result", {32'd0, a_result}, 64'd0);
         check("rst_a_alu_control", {60'd0, a_alu_control}, 64'd0);
         check("rst_a_in_ready", {63'd0, a_in_ready}, 64'd0);
         check("rst_b_in_ready", {63'd0, b_in_ready}, 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_a_in_ready", {63'd0, a_in_ready}, 64'd1);
      check("post_rst_b_in_ready", {63'd0, b_in_ready}, 64'd1);
      @(posedge clk); #1;

      // Decode sweep on the 32-bit instance.
      issue(0, 2'b10, 7'b0110011, 3'b000, 7'b0100000, 64'd5, 64'd7, 64'hFFFF_FFFE, 4'b0001, 1);
      @(negedge clk);
      check("latency_one_cycle", {63'd0, a_out_valid}, 64'd1);
      @(posedge clk); #1;
      issue(0, 2'b10, 7'b0010011, 3'b000, 7'b0100000, 64'd5, 64'd7, 64'd12, 4'b0000, 1);
      issue(0, 2'b10, 7'b0110011, 3'b011, 7'b0000000, 64'hFFFF_FFFF, 64'd1, 64'd0, 4'b0110, 1);
      issue(0, 2'b10, 7'b0110011, 3'b010, 7'b0000000, 64'hFFFF_FFFF, 64'd1, 64'd1, 4'b0101, 1);
      issue(0, 2'b00, 7'b0000011, 3'b010, 7'b0100000, 64'h7FFF_FFFF, 64'd1, 64'h8000_0000, 4'b0000, 1);
      issue(0, 2'b01, 7'b1100011, 3'b000, 7'b0000000, 64'd3, 64'd3, 64'd0, 4'b0001, 1);
      issue(0, 2'b11, 7'b0110111, 3'b000, 7'b0000000, 64'd5, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 4'b1010, 1);
      issue(0, 2'b10, 7'b0110011, 3'b111, 7'b0000000, 64'hF0F0_F0F0, 64'hFF00_FF00, 64'hF000_F000, 4'b0010, 1);
      repeat (2) @(posedge clk);
      #1;

      // Back-pressure: result held while out_ready is low.
      a_out_ready = 1'b0;
      issue(0, 2'b10, 7'b0110011, 3'b100, 7'b0000000, 64'hF0F0_F0F0, 64'hFF00_FF00, 64'h0FF0_0FF0, 4'b0100, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", {63'd0, a_in_ready}, 64'd0);
         check("bp_out_valid", {63'd0, a_out_valid}, 64'd1);
         check("bp_result_stable", {32'd0, a_result}, 64'h0FF0_0FF0);
      end
      @(posedge clk); #1;
      a_out_ready = 1'b1;
      issue(0, 2'b10, 7'b0110011, 3'b110, 7'b0000000, 64'hF0F0_F0F0, 64'h0F00_0000, 64'hFFF0_F0F0, 4'b0011, 1);
      @(negedge clk);
      check("bp_no_bubble_valid", {63'd0, a_out_valid}, 64'd1);
      check("bp_no_bubble_result", {32'd0, a_result}, 64'hFFF0_F0F0);
      @(posedge clk); #1;

      // Serial SRA by 4 (upper bits of src_b ignored): N+1 cycle latency.
      issue(0, 2'b10, 7'b0110011, 3'b101, 7'b0100000, 64'h8000_0000, 64'h24, 64'hF800_0000, 4'b1001, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("sra_busy_in_ready", {63'd0, a_in_ready}, 64'd0);
         check("sra_busy_out_valid", {63'd0, a_out_valid}, 64'd0);
      end
      @(negedge clk);
      check("sra_done_out_valid", {63'd0, a_out_valid}, 64'd1);
      @(posedge clk); #1;

      // Serial shift with amount 0 completes in one cycle.
      issue(0, 2'b10, 7'b0110011, 3'b001, 7'b0000000, 64'h1234_5678, 64'h20, 64'h1234_5678, 4'b0111, 1);
      @(negedge clk);
      check("shamt0_out_valid", {63'd0, a_out_valid}, 64'd1);
      @(posedge clk); #1;
      issue(0, 2'b10, 7'b0110011, 3'b101, 7'b0000000, 64'h8000_0000, 64'd3, 64'h1000_0000, 4'b1000, 1);

      // Flush on the second SHIFT cycle.
      issue(0, 2'b10, 7'b0110011, 3'b001, 7'b0000000, 64'd1, 64'd8, 64'd0, 4'b0111, 0);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      check("flush_blocks_in_ready", {63'd0, a_in_ready}, 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_in_ready", {63'd0, a_in_ready}, 64'd1);
      for (int i = 0; i < 10; i++) begin
         check("flush_no_output", {63'd0, a_out_valid}, 64'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      issue(0, 2'b00, 7'b0110011, 3'b000, 7'b0000000, 64'd3, 64'd4, 64'd7, 4'b0000, 1);

      // 64-bit instance with the barrel shifter.
      issue(1, 2'b11, 7'b0110111, 3'b000, 7'b0000000, 64'd0, 64'h0123_4567_89AB_CDEF,
            64'h0123_4567_89AB_CDEF, 4'b1010, 1);
      issue(1, 2'b00, 7'b0000011, 3'b000, 7'b0000000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
            64'd0, 4'b0000, 1);
      issue(1, 2'b10, 7'b0110011, 3'b101, 7'b0100000, 64'h8000_0000_0000_0000, 64'h44,
            64'hF800_0000_0000_0000, 4'b1001, 1);
      issue(1, 2'b10, 7'b0010011, 3'b001, 7'b0000000, 64'd1, 64'd63,
            64'h8000_0000_0000_0000, 4'b0111, 1);
      issue(1, 2'b10, 7'b0110011, 3'b011, 7'b0000000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
            64'd1, 4'b0110, 1);
      issue(1, 2'b10, 7'b0110011, 3'b101, 7'b0000000, 64'h8000_0000_0000_0000, 64'd60,
            64'd8, 4'b1000, 1);

      // Drain the scoreboards with a bounded wait.
      t = 0;
      while ((qa.size() != 0 || qb.size() != 0) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("a_scoreboard_drained", 64'(qa.size()), 64'd0);
      check("b_scoreboard_drained", 64'(qb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
